iexecute: RTL
=============

// Module: iexecute
// PURPOSE
//  Execute stage of the 5-stage RV32 pipeline. Consumes the ID/EX register outputs, forwards operands, runs the ALU and resolves beq/jal.
//  Drives PCSrcE/PCTargetE back to fetch. Registers results into the EX/MEM pipeline register for the memory stage.
// PARAMETERS
//  XLEN      32   datapath width; all data/PC ports are XLEN bits
//  REGADDR   5    register index width (RdE/RdM)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high; clears EX/MEM register
//  RegWriteE    in   1      EX control: register write
//  MemWriteE    in   1      EX control: data memory write
//  JumpE        in   1      EX control: jal
//  BranchE      in   1      EX control: beq
//  ALUSrcE      in   1      0: SrcB=fwd RD2; 1: SrcB=ImmExtE
//  ResultSrcE   in   2      EX control: writeback select, passed through
//  ALUControlE  in   3      ALU opcode (see BEHAVIOUR)
//  RdE          in   5      destination register
//  PCE          in   XLEN   PC of EX instruction
//  RD1E,RD2E    in   XLEN   register-file operands
//  ImmExtE      in   XLEN   sign-extended immediate
//  PCPlus4E     in   XLEN   PC+4 of EX instruction
//  ForwardAE    in   2      SrcA sel: 00 RD1E, 01 ResultW, 10 ALUResultM, 11 RD1E
//  ForwardBE    in   2      fwd-RD2 sel, same encoding
//  ResultW      in   XLEN   writeback-stage result (forward source)
//  FlushM       in   1      sync bubble insert into EX/MEM
//  PCSrcE       out  1      1: fetch takes PCTargetE next cycle
//  PCTargetE    out  XLEN   branch/jump target
//  RegWriteM,MemWriteM out 1  registered controls
//  ResultSrcM   out  2      registered
//  ALUResultM   out  XLEN   registered ALU result
//  WriteDataM   out  XLEN   registered forwarded RD2 (store data)
//  RdM          out  5      registered destination
//  PCPlus4M     out  XLEN   registered PC+4
// BEHAVIOUR
//  - Comb path: SrcA=mux(ForwardAE); WD=mux(ForwardBE); SrcB=ALUSrcE?ImmExtE:WD.
//  - ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed, result 0/1), 110 sll by SrcB[4:0], 111 srl by SrcB[4:0].
//  - Add/sub wrap modulo 2^XLEN, no overflow flag. ZeroE=(ALUResultE==0).
//  - PCTargetE=PCE+ImmExtE (wraps). PCSrcE=(BranchE&ZeroE)|JumpE; purely combinational, 0-cycle latency.
//  - EX/MEM register: 1-cycle latency, updates every rising edge (no stall input; hazard unit stalls earlier stages only).
//  - reset (async, any time incl. mid-instruction): all *M outputs->0 immediately.
//  - FlushM=1 at edge: RegWriteM,MemWriteM->0, ResultSrcM->00, RdM->0. Data outputs load normally (don't-care).
//  - reset dominates FlushM. Comb outputs (PCSrcE,PCTargetE) are unaffected by reset; with zero inputs PCSrcE=0.
//  - Forward priority is set by the hazard unit; this block only muxes. Encoding 11 behaves as 00.
//  - RdM=0 with RegWriteM=1 is passed through; x0 suppression is in regfile.
// TESTING
//  1. Assert reset mid-cycle with nonzero inputs -> all *M outputs 0 before next edge; PCSrcE follows inputs.
//  2. add: RD1E=5, RD2E=7, ALUSrcE=0, ALUControlE=000, RdE=3, RegWriteE=1 -> next edge ALUResultM=12, RdM=3, RegWriteM=1.
//  3. Forwarding: RD1E=1, ForwardAE=10, ALUResultM=0x20, ALUSrcE=1, ImmExtE=4 -> ALUResultM=0x24 next cycle; ForwardAE=01 with ResultW=9 -> 13.
//  4. beq: BranchE=1, ALUControlE=001, RD1E=RD2E=0x55, PCE=0x100, ImmExtE=0xFFFFFFF8 -> PCSrcE=1, PCTargetE=0xF8; RD2E=0x56 -> PCSrcE=0.
//  5. slt/shift: SrcA=0xFFFFFFFF, SrcB=1, 101 -> 1; SrcA=0x80000000, SrcB=0x21, 111 -> 0x40000000.
//  6. sw with FlushM=1: MemWriteE=1 -> MemWriteM=0, RegWriteM=0, RdM=0; next cycle FlushM=0 -> MemWriteM=1, WriteDataM=fwd RD2.

Source files
------------

// File: rtl/iexecute.sv
// RV32 execute stage: operand forwarding, ALU, beq/jal resolution and the
// EX/MEM pipeline register feeding the memory stage.
module iexecute #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               RegWriteE,
  input  logic               MemWriteE,
  input  logic               JumpE,
  input  logic               BranchE,
  input  logic               ALUSrcE,
  input  logic [1:0]         ResultSrcE,
  input  logic [2:0]         ALUControlE,
  input  logic [REGADDR-1:0] RdE,
  input  logic [XLEN-1:0]    PCE,
  input  logic [XLEN-1:0]    RD1E,
  input  logic [XLEN-1:0]    RD2E,
  input  logic [XLEN-1:0]    ImmExtE,
  input  logic [XLEN-1:0]    PCPlus4E,
  input  logic [1:0]         ForwardAE,
  input  logic [1:0]         ForwardBE,
  input  logic [XLEN-1:0]    ResultW,
  input  logic               FlushM,
  output logic               PCSrcE,
  output logic [XLEN-1:0]    PCTargetE,
  output logic               RegWriteM,
  output logic               MemWriteM,
  output logic [1:0]         ResultSrcM,
  output logic [XLEN-1:0]    ALUResultM,
  output logic [XLEN-1:0]    WriteDataM,
  output logic [REGADDR-1:0] RdM,
  output logic [XLEN-1:0]    PCPlus4M
);

  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_write_data;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_zero;

  logic               r_reg_write;
  logic               r_mem_write;
  logic [1:0]         r_result_src;
  logic [XLEN-1:0]    r_alu_result;
  logic [XLEN-1:0]    r_write_data;
  logic [REGADDR-1:0] r_rd;
  logic [XLEN-1:0]    r_pc_plus4;

  // Select 11 is unused by the hazard unit and falls back to the register file.
  always_comb begin
    w_src_a = RD1E;
    case (ForwardAE)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = r_alu_result;
      default: w_src_a = RD1E;
    endcase
  end

  always_comb begin
    w_write_data = RD2E;
    case (ForwardBE)
      2'b01:   w_write_data = ResultW;
      2'b10:   w_write_data = r_alu_result;
      default: w_write_data = RD2E;
    endcase
  end

  assign w_src_b = ALUSrcE ? ImmExtE : w_write_data;

  always_comb begin
    w_alu_result = '0;
    case (ALUControlE)
      3'b000: w_alu_result = w_src_a + w_src_b;
      3'b001: w_alu_result = w_src_a - w_src_b;
      3'b010: w_alu_result = w_src_a & w_src_b;
      3'b011: w_alu_result = w_src_a | w_src_b;
      3'b100: w_alu_result = w_src_a ^ w_src_b;
      3'b101: w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
      3'b110: w_alu_result = w_src_a << w_src_b[4:0];
      3'b111: w_alu_result = w_src_a >> w_src_b[4:0];
      default: w_alu_result = '0;
    endcase
  end

  assign w_zero    = (w_alu_result == '0);
  assign PCTargetE = PCE + ImmExtE;
  assign PCSrcE    = (BranchE & w_zero) | JumpE;

  // A flush only kills the side-effecting controls; the data fields are
  // don't-care for a bubble and load normally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 2'b00;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_rd         <= '0;
      r_pc_plus4   <= '0;
    end else begin
      r_alu_result <= w_alu_result;
      r_write_data <= w_write_data;
      r_pc_plus4   <= PCPlus4E;
      if (FlushM) begin
        r_reg_write  <= 1'b0;
        r_mem_write  <= 1'b0;
        r_result_src <= 2'b00;
        r_rd         <= '0;
      end else begin
        r_reg_write  <= RegWriteE;
        r_mem_write  <= MemWriteE;
        r_result_src <= ResultSrcE;
        r_rd         <= RdE;
      end
    end
  end

  assign RegWriteM  = r_reg_write;
  assign MemWriteM  = r_mem_write;
  assign ResultSrcM = r_result_src;
  assign ALUResultM = r_alu_result;
  assign WriteDataM = r_write_data;
  assign RdM        = r_rd;
  assign PCPlus4M   = r_pc_plus4;

endmodule
